// File: rtl/tx_frame_padder.sv
// Zero-pads runt Ethernet frames to MIN_FRAME_BYTES and clips oversize frames at MAX_FRAME_BYTES.
// One registered output stage (1 cycle); input is held off while pad beats are generated.
module tx_frame_padder #(
  parameter int DATA_WIDTH      = 16,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH*8-1:0] s_axis_tdata,
  input  logic [DATA_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH*8-1:0] m_axis_tdata,
  output logic [DATA_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_padded,
  output logic [31:0]             stat_truncated
);

  localparam int CW = 16;
  localparam logic [CW-1:0] MIN_B = CW'(MIN_FRAME_BYTES);
  localparam logic [CW-1:0] MAX_B = CW'(MAX_FRAME_BYTES);
  localparam logic [CW-1:0] DW_B  = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {PASS, PAD, DROP} state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] n_bytes;
  logic [CW-1:0] tot;
  logic          out_load;
  logic          in_acc;

  function automatic logic [DATA_WIDTH-1:0] keep_lsb(input logic [CW-1:0] cnt);
    logic [DATA_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_WIDTH; i++) k[i] = (CW'(i) < cnt);
    return k;
  endfunction

  function automatic logic [DATA_WIDTH*8-1:0] zero_unkept(input logic [DATA_WIDTH*8-1:0] d,
                                                          input logic [DATA_WIDTH-1:0]   k);
    logic [DATA_WIDTH*8-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    n_bytes = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n_bytes = n_bytes + CW'(s_axis_tkeep[i]);
    tot      = byte_cnt + n_bytes;
    out_load = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = 1'b0;
    if (!reset) begin
      case (state)
        PASS:    s_axis_tready = out_load;
        DROP:    s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
    in_acc = s_axis_tvalid && s_axis_tready;
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state          <= PASS;
      byte_cnt       <= '0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      stat_frames    <= '0;
      stat_padded    <= '0;
      stat_truncated <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) stat_frames <= stat_frames + 32'd1;

      case (state)
        PASS: begin
          // in_acc already implies the output register is free to load
          if (in_acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= 1'b0;
            if (tot >= MAX_B && !(s_axis_tlast && tot == MAX_B)) begin
              m_axis_tdata   <= s_axis_tdata;
              m_axis_tkeep   <= keep_lsb(MAX_B - byte_cnt);
              m_axis_tlast   <= 1'b1;
              m_axis_tuser   <= 1'b1;
              stat_truncated <= stat_truncated + 32'd1;
              byte_cnt       <= '0;
              state          <= s_axis_tlast ? PASS : DROP;
            end else if (s_axis_tlast && tot >= MIN_B) begin
              m_axis_tdata <= s_axis_tdata;
              m_axis_tkeep <= s_axis_tkeep;
              m_axis_tlast <= 1'b1;
              byte_cnt     <= '0;
            end else if (s_axis_tlast) begin
              m_axis_tdata <= zero_unkept(s_axis_tdata, s_axis_tkeep);
              stat_padded  <= stat_padded + 32'd1;
              if (byte_cnt + DW_B >= MIN_B) begin
                m_axis_tkeep <= keep_lsb(MIN_B - byte_cnt);
                m_axis_tlast <= 1'b1;
                byte_cnt     <= '0;
              end else begin
                m_axis_tkeep <= '1;
                m_axis_tlast <= 1'b0;
                byte_cnt     <= byte_cnt + DW_B;
                state        <= PAD;
              end
            end else begin
              m_axis_tdata <= s_axis_tdata;
              m_axis_tkeep <= s_axis_tkeep;
              m_axis_tlast <= 1'b0;
              byte_cnt     <= tot;
            end
          end else if (out_load) begin
            m_axis_tvalid <= 1'b0;
          end
        end

        PAD: begin
          if (out_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            if (MIN_B - byte_cnt > DW_B) begin
              m_axis_tkeep <= '1;
              m_axis_tlast <= 1'b0;
              byte_cnt     <= byte_cnt + DW_B;
            end else begin
              m_axis_tkeep <= keep_lsb(MIN_B - byte_cnt);
              m_axis_tlast <= 1'b1;
              byte_cnt     <= '0;
              state        <= PASS;
            end
          end
        end

        DROP: begin
          // the truncated tlast beat may still be waiting on the router
          if (out_load) m_axis_tvalid <= 1'b0;
          if (s_axis_tvalid && s_axis_tlast) state <= PASS;
        end

        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_padder.sv
// Bench for tx_frame_padder: fixed frame-length vectors, stall/reset sequences and random frames
// checked against a byte-level frame model (pad to MIN, clip at MAX, chunk into beats).
module tb_tx_frame_padder;

  localparam int DW  = 16;
  localparam int MIN = 60;
  localparam int MAX = 1514;

  logic            user_clk;
  logic            reset;
  logic [DW*8-1:0] s_axis_tdata;
  logic [DW-1:0]   s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic [DW*8-1:0] m_axis_tdata;
  logic [DW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic            m_axis_tready;
  logic [31:0]     stat_frames;
  logic [31:0]     stat_padded;
  logic [31:0]     stat_truncated;

  tx_frame_padder #(.DATA_WIDTH(DW), .MIN_FRAME_BYTES(MIN), .MAX_FRAME_BYTES(MAX)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .stat_frames(stat_frames), .stat_padded(stat_padded), .stat_truncated(stat_truncated)
  );

  typedef struct packed {
    logic [DW*8-1:0] d;
    logic [DW-1:0]   k;
    logic            l;
    logic            u;
  } beat_t;

  typedef struct {
    int          len;
    int          beats;
    logic [15:0] last_keep;
    logic        last_user;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         frames_exp = 0;
  int         padded_exp = 0;
  int         trunc_exp = 0;
  int         rdy_mode = 0;
  logic [7:0] fb[$];
  beat_t      exp_q[$];
  beat_t      obs_q[$];
  beat_t      stall_beat;
  logic       stall_vld = 1'b0;
  vec_t       tab[14];

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic check(input string name, input logic [DW*8-1:0] act, input logic [DW*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW*8-1:0] mask(input logic [DW*8-1:0] d, input logic [DW-1:0] k);
    logic [DW*8-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // router ready: 0 = always, 1 = alternating, 2 = random
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      case (rdy_mode)
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // output monitor: collects handshaken beats and checks hold-while-stalled
  initial begin
    beat_t cur;
    forever begin
      @(negedge user_clk);
      cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast, u: m_axis_tuser};
      if (reset) begin
        stall_vld = 1'b0;
      end else begin
        if (stall_vld) begin
          check("stall_valid", m_axis_tvalid, 1);
          check("stall_data", cur.d, stall_beat.d);
          check("stall_ctl", {cur.k, cur.l, cur.u}, {stall_beat.k, stall_beat.l, stall_beat.u});
        end
        if (m_axis_tvalid && m_axis_tready) obs_q.push_back(cur);
        stall_vld  = m_axis_tvalid && !m_axis_tready;
        stall_beat = cur;
      end
    end
  end

  task automatic build_frame(input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
  endtask

  // reference: pad the byte stream to MIN or clip it to MAX, then slice into DW-byte beats
  task automatic model_frame();
    int    len;
    int    out_len;
    bit    trunc;
    bit    pad;
    beat_t bt;
    len     = fb.size();
    trunc   = len > MAX;
    pad     = len < MIN;
    out_len = trunc ? MAX : (pad ? MIN : len);
    for (int b = 0; b * DW < out_len; b++) begin
      bt = '0;
      for (int i = 0; i < DW; i++)
        if (b * DW + i < out_len) begin
          bt.k[i] = 1'b1;
          bt.d[i*8 +: 8] = (b * DW + i < len) ? fb[b * DW + i] : 8'h00;
        end
      bt.l = ((b + 1) * DW >= out_len);
      bt.u = bt.l && trunc;
      exp_q.push_back(bt);
    end
    frames_exp++;
    padded_exp += int'(pad);
    trunc_exp  += int'(trunc);
  endtask

  task automatic set_beat(input int b);
    int n;
    n = fb.size() - b * DW;
    if (n > DW) n = DW;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata[i*8 +: 8] = fb[b * DW + i];
      s_axis_tkeep[i] = 1'b1;
    end
    s_axis_tlast  = (b * DW + n >= fb.size());
    s_axis_tvalid = 1'b1;
  endtask

  task automatic drive_beat(input int b);
    int t;
    set_beat(b);
    t = 0;
    forever begin
      @(negedge user_clk);
      if (s_axis_tready) break;
      t++;
      if (t > 4000) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: beat %0d never accepted", b);
        break;
      end
    end
    @(posedge user_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps);
    for (int b = 0; b * DW < fb.size(); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge user_clk);
        #1;
      end
      drive_beat(b);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 20000) begin
      @(negedge user_clk);
      t++;
    end
    if (obs_q.size() < exp_q.size()) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    repeat (3) @(negedge user_clk);
    @(posedge user_clk);
    #1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_beats"}, 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_data"}, mask(obs_q[i].d, obs_q[i].k), exp_q[i].d);
      check({tag, "_ctl"}, {obs_q[i].k, obs_q[i].l, obs_q[i].u}, {exp_q[i].k, exp_q[i].l, exp_q[i].u});
    end
    check({tag, "_stat_frames"}, stat_frames, 128'(frames_exp));
    check({tag, "_stat_padded"}, stat_padded, 128'(padded_exp));
    check({tag, "_stat_trunc"}, stat_truncated, 128'(trunc_exp));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tab[0]  = '{24,   4,  16'h0FFF, 1'b0};
    tab[1]  = '{60,   4,  16'h0FFF, 1'b0};
    tab[2]  = '{1600, 95, 16'h03FF, 1'b1};
    tab[3]  = '{1514, 95, 16'h03FF, 1'b0};
    tab[4]  = '{64,   4,  16'hFFFF, 1'b0};
    tab[5]  = '{59,   4,  16'h0FFF, 1'b0};
    tab[6]  = '{61,   4,  16'h1FFF, 1'b0};
    tab[7]  = '{1,    4,  16'h0FFF, 1'b0};
    tab[8]  = '{16,   4,  16'h0FFF, 1'b0};
    tab[9]  = '{50,   4,  16'h0FFF, 1'b0};
    tab[10] = '{1513, 95, 16'h01FF, 1'b0};
    tab[11] = '{1515, 95, 16'h03FF, 1'b1};
    tab[12] = '{1520, 95, 16'h03FF, 1'b1};
    tab[13] = '{1530, 95, 16'h03FF, 1'b1};

    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    check("rst_stats", {stat_frames, stat_padded, stat_truncated}, 0);
    @(posedge user_clk);
    #1;
    reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      build_frame(tab[v].len);
      model_frame();
      drive_frame(1'b0);
      drain();
      if (obs_q.size() > 0) begin
        check($sformatf("vec%0d_nbeats", tab[v].len), 128'(obs_q.size()), 128'(tab[v].beats));
        check($sformatf("vec%0d_last_keep", tab[v].len), obs_q[obs_q.size()-1].k, tab[v].last_keep);
        check($sformatf("vec%0d_last_user", tab[v].len), obs_q[obs_q.size()-1].u, tab[v].last_user);
      end else begin
        check($sformatf("vec%0d_nbeats", tab[v].len), 0, 128'(tab[v].beats));
      end
      compare_q($sformatf("vec%0d", tab[v].len));
    end

    // back-to-back 64 B frames into an alternating router ready
    rdy_mode = 1;
    for (int f = 0; f < 4; f++) begin
      build_frame(64);
      model_frame();
      drive_frame(1'b0);
    end
    drain();
    compare_q("b2b64");

    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 3))
        0:       build_frame(int'($urandom_range(1, 70)));
        1:       build_frame(int'($urandom_range(50, 200)));
        2:       build_frame(int'($urandom_range(1490, 1540)));
        default: build_frame(int'($urandom_range(1, 1700)));
      endcase
      model_frame();
      drive_frame(1'b1);
      if (f % 5 == 4) begin
        drain();
        compare_q("rand");
      end
    end

    // reset while beat 2 of a 100 B frame is being offered
    rdy_mode = 0;
    build_frame(100);
    drive_beat(0);
    drive_beat(1);
    set_beat(2);
    reset = 1'b1;
    @(negedge user_clk);
    check("midrst_s_tready", s_axis_tready, 0);
    @(posedge user_clk);
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_m_tdata", m_axis_tdata, 0);
    check("midrst_m_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    check("midrst_stats", {stat_frames, stat_padded, stat_truncated}, 0);
    reset         = 1'b0;
    s_axis_tvalid = 1'b0;
    obs_q.delete();
    exp_q.delete();
    frames_exp = 0;
    padded_exp = 0;
    trunc_exp  = 0;
    @(posedge user_clk);
    #1;
    build_frame(100);
    model_frame();
    drive_frame(1'b0);
    drain();
    compare_q("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
